// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle ARM-subset datapath: sequences each instruction
// through the shared ALU and memory port and drives per-state enables and mux selects.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      StFetch:  if (MemReady) state_d = StDecode;
      StDecode: begin
        unique case (Op)
          2'b00: state_d = Funct[5] ? StExecI : StExecR;
          2'b01: state_d = StMemAdr;
          2'b10: state_d = StBranch;
          2'b11: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = Funct[0] ? StMemRd : StMemWr;
      StMemRd:  if (MemReady) state_d = StMemWb;
      StMemWr:  if (MemReady) state_d = StFetch;
      StExecR,
      StExecI:  state_d = StAluWb;
      StMemWb,
      StAluWb,
      StBranch: state_d = StFetch;
      // Unused encodings recover to fetch.
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    case (state_q)
      StFetch: begin
        IRWrite   = MemReady;
        NextPC    = MemReady;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      // PC+8 is formed here so R15 reads see the architectural value.
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr: ALUSrcB = 2'b01;
      StMemRd:  AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      StMemWr: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      StExecR:  ALUOp = 1'b1;
      StExecI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      StAluWb:  RegW = 1'b1;
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign Illegal = illegal_q;
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of per-cycle vectors plus hand-written
// reset-abort sequences.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc;
  logic       RegW, MemW, Branch, ALUOp, Illegal;
  logic [3:0] State;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .MemReady  (MemReady),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .Illegal   (Illegal),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        mr;
    logic [3:0]  st;
    logic [12:0] outs;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // outs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, RegW, MemW, Branch, ALUOp, Illegal}
  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] funct, input logic mr,
                              input logic [3:0] st, input logic irw, input logic npc,
                              input logic adr, input logic srca, input logic [1:0] srcb,
                              input logic [1:0] rsrc, input logic regw, input logic memw,
                              input logic br, input logic aluop, input logic ill);
    vec_t v;
    v.op    = op;
    v.funct = funct;
    v.mr    = mr;
    v.st    = st;
    v.outs  = {irw, npc, adr, srca, srcb, rsrc, regw, memw, br, aluop, ill};
    return v;
  endfunction

  function automatic logic [12:0] outs_now();
    return {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, RegW, MemW, Branch, ALUOp,
            Illegal};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] op, input logic [5:0] funct, input logic mr);
    Op       = op;
    Funct    = funct;
    MemReady = mr;
  endtask

  initial begin
    logic [1:0] o;
    logic [5:0] f;
    reset = 1'b0;
    set_in(2'b00, 6'b0, 1'b1);

    // ADD immediate: 0,1,7,8
    o = 2'b00; f = 6'b101000;
    vecs.push_back(mk(o, f, 1, 0, 1, 1, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 7, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(o, f, 1, 8, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0));
    // LDR with two wait cycles in MEMRD: 0,1,2,3,3,3,4
    o = 2'b01; f = 6'b011001;
    vecs.push_back(mk(o, f, 1, 0, 1, 1, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 2, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 0, 3, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 0, 3, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 3, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 4, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 0, 0, 0));
    // STR with a FETCH wait, then a MEMWR wait: 0,0,1,2,5,5
    o = 2'b01; f = 6'b011000;
    vecs.push_back(mk(o, f, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 0, 1, 1, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 2, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 0, 5, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 5, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0));
    // ADD register: 0,1,6,8
    o = 2'b00; f = 6'b001000;
    vecs.push_back(mk(o, f, 1, 0, 1, 1, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 6, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(o, f, 1, 8, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0));
    // B: 0,1,9
    o = 2'b10; f = 6'b000001;
    vecs.push_back(mk(o, f, 1, 0, 1, 1, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 9, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 1, 0, 0));
    // Illegal: 0,1,0 with Illegal high for exactly the one FETCH that follows
    o = 2'b11; f = 6'b000000;
    vecs.push_back(mk(o, f, 1, 0, 1, 1, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(o, f, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 1));
    vecs.push_back(mk(o, f, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0));

    #12;
    chk("reset state", 16'(State), 16'd0);
    chk("reset illegal", 16'(Illegal), 16'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].op, vecs[i].funct, vecs[i].mr);
      #1;
      chk($sformatf("row%0d state", i), 16'(State), 16'(vecs[i].st));
      chk($sformatf("row%0d outs", i), 16'(outs_now()), 16'(vecs[i].outs));
      @(negedge clk);
    end

    // Reset mid-LDR while MEMRD is waiting.
    set_in(2'b01, 6'b000001, 1'b1);
    repeat (3) @(negedge clk);
    MemReady = 1'b0;
    #2;
    chk("ldr reach memrd", 16'(State), 16'd3);
    reset = 1'b0;
    #1;
    chk("ldr abort state", 16'(State), 16'd0);
    for (int i = 0; i < 3; i++) begin
      MemReady = 1'b1;
      @(negedge clk);
      #1;
      chk($sformatf("ldr abort wr%0d", i), 16'({RegW, MemW}), 16'd0);
      chk($sformatf("ldr abort st%0d", i), 16'(State), 16'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post reset irwrite", 16'({IRWrite, NextPC}), 16'b11);
    @(negedge clk);
    #1;
    chk("post reset decode", 16'(State), 16'd1);

    // Reset mid-STR while MEMWR waits: MemW must drop at once.
    set_in(2'b01, 6'b000000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    #2;
    chk("str memw held", 16'({State, MemW}), 16'h0b);
    reset = 1'b0;
    #1;
    chk("str abort", 16'({State, MemW}), 16'h00);
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'b1;

    // Reset clears a pending Illegal asynchronously.
    set_in(2'b11, 6'b000000, 1'b1);
    @(negedge clk);
    MemReady = 1'b0;
    @(negedge clk);
    #1;
    chk("illegal set", 16'({State, Illegal}), 16'h01);
    reset = 1'b0;
    #1;
    chk("illegal cleared", 16'(Illegal), 16'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
